// File: rtl/hazard_fwd_unit_if.sv
// Decode-side hazard bus: instruction fields entering from D, branch
// resolution from M, and the stall/flush/forwarding controls sent back.
interface hazard_fwd_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                      dec_valid;
  logic [NUM_SRC*REG_AW-1:0] dec_src;
  logic [NUM_SRC-1:0]        dec_src_used;
  logic [REG_AW-1:0]         dec_dst;
  logic                      dec_reg_write;
  logic                      dec_load;
  logic                      branch_taken_m;
  logic                      stall_fd;
  logic                      bubble_e;
  logic                      flush_de;
  logic [NUM_SRC*2-1:0]      fwd_sel_e;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output dec_valid, dec_src, dec_src_used, dec_dst, dec_reg_write, dec_load,
           branch_taken_m,
    input  stall_fd, bubble_e, flush_de, fwd_sel_e, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_src, dec_src_used, dec_dst, dec_reg_write, dec_load,
           branch_taken_m,
    output stall_fd, bubble_e, flush_de, fwd_sel_e, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline.
// Shadows the E and M destination registers, stalls on load-use for a
// configurable number of bubbles, flushes D/E on a taken branch from M and
// keeps saturating stall/flush statistics.
module hazard_fwd_unit #(
  parameter int REG_AW         = 5,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  hazard_fwd_unit_if.slave   bus
);

  typedef enum logic {RUN, STALL} stateT;

  stateT                stateCur, stateNext;
  logic [2:0]           stallLeft, stallLeftNext;

  // Shadow slots: _p0 is the instruction in E, _p1 the one in M. The W slot
  // is not kept: it never feeds a forwarding or hazard decision.
  logic                 vld_p0, vld_p1;
  logic [REG_AW-1:0]    dst_p0, dst_p1;
  logic                 regWr_p0, regWr_p1;
  logic                 isLoad_p0;

  logic                 eligE, eligM, loadUse;
  logic                 stallFd, bubbleE, flushDe, accept;
  logic [NUM_SRC*2-1:0] selNext, fwdSel;
  logic [CNT_W-1:0]     stallCnt, flushCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v,
                                              input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  assign eligE  = vld_p0 && regWr_p0 && (dst_p0 != '0);
  assign eligM  = vld_p1 && regWr_p1 && (dst_p1 != '0);
  assign accept = bus.dec_valid && !stallFd && !flushDe;

  // Load in E whose result is needed by a used operand of the D instruction.
  always_comb begin
    loadUse = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.dec_valid && bus.dec_src_used[i] && eligE && isLoad_p0 &&
          (bus.dec_src[i*REG_AW +: REG_AW] == dst_p0))
        loadUse = 1'b1;
    end
  end

  // Stall FSM next state and pipeline controls; a taken branch overrides any stall.
  always_comb begin
    stateNext     = stateCur;
    stallLeftNext = stallLeft;
    stallFd       = 1'b0;
    bubbleE       = 1'b0;
    flushDe       = 1'b0;
    if (bus.branch_taken_m) begin
      flushDe       = 1'b1;
      stateNext     = RUN;
      stallLeftNext = '0;
    end else begin
      case (stateCur)
        RUN: begin
          if (loadUse) begin
            stallFd       = 1'b1;
            bubbleE       = 1'b1;
            stallLeftNext = 3'(LOAD_USE_STALL - 1);
            stateNext     = (LOAD_USE_STALL > 1) ? STALL : RUN;
          end
        end
        STALL: begin
          stallFd       = 1'b1;
          bubbleE       = 1'b1;
          stallLeftNext = stallLeft - 3'd1;
          if (stallLeft <= 3'd1) stateNext = RUN;
        end
        default: stateNext = RUN;
      endcase
    end
  end

  // Forwarding select for the instruction entering E; the younger (E) writer wins.
  always_comb begin
    selNext = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept && bus.dec_src_used[i]) begin
        if (eligE && !isLoad_p0 && (dst_p0 == bus.dec_src[i*REG_AW +: REG_AW]))
          selNext[2*i +: 2] = 2'd1;
        else if (eligM && (dst_p1 == bus.dec_src[i*REG_AW +: REG_AW]))
          selNext[2*i +: 2] = 2'd2;
      end
    end
  end

  // Control state: FSM, shadow valid bits, forwarding selects and statistics.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateCur  <= RUN;
      stallLeft <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      fwdSel    <= '0;
      stallCnt  <= '0;
      flushCnt  <= '0;
    end else begin
      stateCur  <= stateNext;
      stallLeft <= stallLeftNext;
      // E -> M boundary: a taken branch kills the wrong-path instruction in E.
      vld_p1    <= vld_p0 && !flushDe;
      // D -> E boundary: stall inserts a bubble, flush an invalid entry.
      vld_p0    <= accept;
      fwdSel    <= selNext;
      stallCnt  <= satInc(stallCnt, stallFd);
      flushCnt  <= satInc(flushCnt, flushDe);
    end
  end

  // Shadow payload follows the pipeline; meaning is qualified by the valid bits.
  always_ff @(posedge Clk) begin
    dst_p1    <= dst_p0;
    regWr_p1  <= regWr_p0;
    dst_p0    <= bus.dec_dst;
    regWr_p0  <= bus.dec_reg_write;
    isLoad_p0 <= bus.dec_load;
  end

  assign bus.stall_fd  = stallFd && !Rst;
  assign bus.bubble_e  = bubbleE && !Rst;
  assign bus.flush_de  = flushDe && !Rst;
  assign bus.fwd_sel_e = fwdSel;
  assign bus.stall_cnt = stallCnt;
  assign bus.flush_cnt = flushCnt;

endmodule
